// File: rtl/coin_credit_ctrl.sv
// Coin payment front-end for the washer: collects credit, charges the single or
// double wash price, returns change and holds coin_in until the wash completes.
module coin_credit_ctrl #(
    parameter int PRICE_SINGLE = 4,
    parameter int PRICE_DOUBLE = 6,
    parameter int TIMEOUT_CYC  = 16,
    parameter int CREDIT_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                double_sel,
    input  logic                cancel,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                busy
);

    // state   | meaning
    // IDLE    | no credit, waiting for the first coin
    // COLLECT | accumulating credit, idle timer running
    // RUN     | wash started, coin_in held until wash_done

    typedef enum logic [1:0] {IDLE, COLLECT, RUN} state_t;

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]    TMR_LOAD   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W-1:0] P_SINGLE   = CREDIT_W'(PRICE_SINGLE);
    localparam logic [CREDIT_W-1:0] P_DOUBLE   = CREDIT_W'(PRICE_DOUBLE);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_in_q, coin_in_d;
    logic                dw_q, dw_d;
    logic                chg_v_q, chg_v_d;
    logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
    logic                rej_q, rej_d;
    logic                busy_q;

    logic                coin_ok;
    logic [CREDIT_W:0]   coin_ext;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] price;

    assign coin_ok  = coin_valid && (coin_val != 2'd0);
    assign coin_ext = {{(CREDIT_W-1){1'b0}}, coin_val};
    assign sum      = {1'b0, credit_q} + coin_ext;
    assign price    = double_sel ? P_DOUBLE : P_SINGLE;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        credit_d  = credit_q;
        coin_in_d = coin_in_q;
        dw_d      = dw_q;
        chg_v_d   = 1'b0;
        chg_amt_d = chg_amt_q;
        rej_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_ok) begin
                    credit_d = coin_ext[CREDIT_W-1:0];
                    timer_d  = TMR_LOAD;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    chg_v_d   = 1'b1;
                    chg_amt_d = credit_q;
                    credit_d  = '0;
                    rej_d     = coin_ok;
                    state_d   = IDLE;
                end else if (credit_q >= price) begin
                    coin_in_d = 1'b1;
                    dw_d      = double_sel;
                    chg_v_d   = 1'b1;
                    chg_amt_d = credit_q - price;
                    credit_d  = '0;
                    rej_d     = coin_ok;
                    state_d   = RUN;
                end else if (coin_ok && (sum <= CREDIT_MAX)) begin
                    credit_d = sum[CREDIT_W-1:0];
                    timer_d  = TMR_LOAD;
                end else begin
                    // An overflowing coin is refused and does not hold off the timeout.
                    rej_d = coin_ok;
                    if (timer_q == '0) begin
                        chg_v_d   = 1'b1;
                        chg_amt_d = credit_q;
                        credit_d  = '0;
                        state_d   = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            RUN: begin
                rej_d = coin_ok;
                if (wash_done) begin
                    coin_in_d = 1'b0;
                    dw_d      = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            credit_q  <= '0;
            coin_in_q <= 1'b0;
            dw_q      <= 1'b0;
            chg_v_q   <= 1'b0;
            chg_amt_q <= '0;
            rej_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            credit_q  <= credit_d;
            coin_in_q <= coin_in_d;
            dw_q      <= dw_d;
            chg_v_q   <= chg_v_d;
            chg_amt_q <= chg_amt_d;
            rej_q     <= rej_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign coin_in      = coin_in_q;
    assign double_wash  = dw_q;
    assign credit       = credit_q;
    assign change_valid = chg_v_q;
    assign change_amt   = chg_amt_q;
    assign coin_reject  = rej_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed bench for coin_credit_ctrl: vector table plus timeout, reset and
// narrow-credit overflow sequences.
module tb_coin_credit_ctrl;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       double_sel;
    logic       cancel;
    logic       wash_done;

    logic       coin_in, double_wash, change_valid, coin_reject, busy;
    logic [3:0] credit, change_amt;

    logic       coin_in2, double_wash2, change_valid2, coin_reject2, busy2;
    logic [2:0] credit2, change_amt2;

    int checks   = 0;
    int failures = 0;

    coin_credit_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_val(coin_val), .double_sel(double_sel),
        .cancel(cancel), .wash_done(wash_done),
        .coin_in(coin_in), .double_wash(double_wash), .credit(credit),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .busy(busy)
    );

    coin_credit_ctrl #(.PRICE_SINGLE(7), .PRICE_DOUBLE(7), .TIMEOUT_CYC(16), .CREDIT_W(3)) dut_narrow (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_val(coin_val), .double_sel(double_sel),
        .cancel(cancel), .wash_done(wash_done),
        .coin_in(coin_in2), .double_wash(double_wash2), .credit(credit2),
        .change_valid(change_valid2), .change_amt(change_amt2),
        .coin_reject(coin_reject2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [1:0]  val;
        logic        ds;
        logic        can;
        logic        wd;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output word: {coin_in, double_wash, credit, change_valid, change_amt, coin_reject, busy}
    function automatic logic [12:0] mk(input logic ci, input logic dw, input logic [3:0] cr,
                                       input logic cv, input logic [3:0] ca,
                                       input logic rj, input logic bz);
        return {ci, dw, cr, cv, ca, rj, bz};
    endfunction

    function automatic logic [10:0] mk2(input logic ci, input logic dw, input logic [2:0] cr,
                                        input logic cv, input logic [2:0] ca,
                                        input logic rj, input logic bz);
        return {ci, dw, cr, cv, ca, rj, bz};
    endfunction

    function automatic vec_t v(input logic cv, input logic [1:0] val, input logic ds,
                               input logic can, input logic wd, input logic [12:0] exp);
        vec_t r;
        r.cv = cv; r.val = val; r.ds = ds; r.can = can; r.wd = wd; r.exp = exp;
        return r;
    endfunction

    task automatic step(input logic cv, input logic [1:0] val, input logic ds,
                        input logic can, input logic wd);
        coin_valid = cv;
        coin_val   = val;
        double_sel = ds;
        cancel     = can;
        wash_done  = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {coin_in, double_wash, credit, change_valid, change_amt, coin_reject, busy};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ci=%b dw=%b cr=%0d cv=%b ca=%0d rj=%b bz=%b, want ci=%b dw=%b cr=%0d cv=%b ca=%0d rj=%b bz=%b",
                     name, act[12], act[11], act[10:7], act[6], act[5:2], act[1], act[0],
                     exp[12], exp[11], exp[10:7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic check2(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {coin_in2, double_wash2, credit2, change_valid2, change_amt2, coin_reject2, busy2};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ci=%b dw=%b cr=%0d cv=%b ca=%0d rj=%b bz=%b, want ci=%b dw=%b cr=%0d cv=%b ca=%0d rj=%b bz=%b",
                     name, act[10], act[9], act[8:6], act[5], act[4:2], act[1], act[0],
                     exp[10], exp[9], exp[8:6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Idle cycles that must neither refund nor drop out of COLLECT.
    task automatic idle_quiet(input string name, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            if (change_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: got %0d early refund/idle cycles, want 0", name, bad);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        coin_valid = 1'b0; coin_val = 2'd0; double_sel = 1'b0; cancel = 1'b0; wash_done = 1'b0;

        // single wash, change 1, coin during RUN, wash_done
        vecs.push_back(v(1, 2'd3, 0, 0, 0, mk(0, 0, 3, 0, 0, 0, 1)));
        vecs.push_back(v(1, 2'd2, 0, 0, 0, mk(0, 0, 5, 0, 0, 0, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, mk(1, 0, 0, 1, 1, 0, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 1)));
        vecs.push_back(v(1, 2'd3, 0, 0, 0, mk(1, 0, 0, 0, 1, 1, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0)));
        // double wash selected late: credit 4 does not start at price 6
        vecs.push_back(v(1, 2'd3, 0, 0, 0, mk(0, 0, 3, 0, 1, 0, 1)));
        vecs.push_back(v(1, 2'd1, 0, 0, 0, mk(0, 0, 4, 0, 1, 0, 1)));
        vecs.push_back(v(0, 2'd0, 1, 0, 0, mk(0, 0, 4, 0, 1, 0, 1)));
        vecs.push_back(v(1, 2'd2, 1, 0, 0, mk(0, 0, 6, 0, 1, 0, 1)));
        vecs.push_back(v(0, 2'd0, 1, 0, 0, mk(1, 1, 0, 1, 0, 0, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0)));
        // cancel racing a coin; cancel and zero-value coin in IDLE
        vecs.push_back(v(1, 2'd2, 0, 0, 0, mk(0, 0, 2, 0, 0, 0, 1)));
        vecs.push_back(v(1, 2'd1, 0, 1, 0, mk(0, 0, 0, 1, 2, 1, 0)));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, mk(0, 0, 0, 0, 2, 0, 0)));
        vecs.push_back(v(1, 2'd0, 0, 0, 0, mk(0, 0, 0, 0, 2, 0, 0)));
        // double wash 3+3, coin in the start cycle and during RUN rejected
        vecs.push_back(v(1, 2'd3, 1, 0, 0, mk(0, 0, 3, 0, 2, 0, 1)));
        vecs.push_back(v(1, 2'd3, 1, 0, 0, mk(0, 0, 6, 0, 2, 0, 1)));
        vecs.push_back(v(1, 2'd1, 1, 0, 0, mk(1, 1, 0, 1, 0, 1, 1)));
        vecs.push_back(v(1, 2'd2, 1, 0, 0, mk(1, 1, 0, 0, 0, 1, 1)));
        vecs.push_back(v(0, 2'd0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0)));
        // cancel outranks a start when credit already covers the price
        vecs.push_back(v(1, 2'd3, 0, 0, 0, mk(0, 0, 3, 0, 0, 0, 1)));
        vecs.push_back(v(1, 2'd1, 0, 0, 0, mk(0, 0, 4, 0, 0, 0, 1)));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, mk(0, 0, 0, 1, 4, 0, 0)));

        #12;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
        check2("reset_state_narrow", mk2(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cv, vecs[i].val, vecs[i].ds, vecs[i].can, vecs[i].wd);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // timeout: refund follows the 16th idle cycle
        step(1, 2'd1, 0, 0, 0);
        check("to_coin", mk(0, 0, 1, 0, 4, 0, 1));
        idle_quiet("to_wait", 15);
        step(0, 2'd0, 0, 0, 0);
        check("to_refund", mk(0, 0, 0, 1, 1, 0, 0));

        // coin in the last idle cycle restarts the timer
        step(1, 2'd1, 0, 0, 0);
        check("to2_coin", mk(0, 0, 1, 0, 1, 0, 1));
        idle_quiet("to2_wait", 15);
        step(1, 2'd1, 0, 0, 0);
        check("to2_late_coin", mk(0, 0, 2, 0, 1, 0, 1));
        idle_quiet("to2_rewait", 15);
        step(0, 2'd0, 0, 0, 0);
        check("to2_refund", mk(0, 0, 0, 1, 2, 0, 0));

        // asynchronous reset in RUN
        step(1, 2'd3, 1, 0, 0);
        step(1, 2'd3, 1, 0, 0);
        step(0, 2'd0, 1, 0, 0);
        check("rst_run", mk(1, 1, 0, 1, 0, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2'd2, 0, 0, 0);
        check("rst_after", mk(0, 0, 2, 0, 0, 0, 1));

        // 3-bit credit, price 7: 6 + 3 overflows, 6 + 1 fits
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2'd3, 0, 0, 0);
        check2("ovf_c3", mk2(0, 0, 3, 0, 0, 0, 1));
        step(1, 2'd3, 0, 0, 0);
        check2("ovf_c6", mk2(0, 0, 6, 0, 0, 0, 1));
        step(1, 2'd3, 0, 0, 0);
        check2("ovf_reject", mk2(0, 0, 6, 0, 0, 1, 1));
        step(1, 2'd1, 0, 0, 0);
        check2("ovf_fill7", mk2(0, 0, 7, 0, 0, 0, 1));
        step(0, 2'd0, 0, 0, 0);
        check2("ovf_start", mk2(1, 0, 0, 1, 0, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
